// File: rtl/execute_stage_mc.sv
// execute_stage_mc: execute stage with valid/ready handshake, flush, operand forwarding
// and an iterative RV32M/RV64M multiply/divide unit beside the single-cycle ALU.
module execute_stage_mc #(
    parameter int WIDTH     = 32,
    parameter int REG_W     = 5,
    parameter bit MULDIV_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_v_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic [WIDTH-1:0] imm_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [2:0]       funct3_i,
    input  logic             alt_i,
    input  logic             imm_v_i,
    input  logic             rs1_pc_sel_i,
    input  logic             imm_pass_i,
    input  logic             m_v_i,
    input  logic             fwd_ex_rs1_i,
    input  logic             fwd_ex_rs2_i,
    input  logic             fwd_mem_rs1_i,
    input  logic             fwd_mem_rs2_i,
    input  logic [WIDTH-1:0] mem_result_i,
    output logic             out_v_o,
    input  logic             out_ready_i,
    output logic [REG_W-1:0] out_rd_o,
    output logic [WIDTH-1:0] out_result_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o
);
    localparam int SH = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state;
    logic [SH-1:0]      cnt;
    logic [WIDTH-1:0]   fwd_rs1, fwd_rs2, op_a, op_b, alu_raw, alu_res, sra;
    logic [WIDTH-1:0]   hi, lo, mc, md_data, md_res, quo, rem, abs_a, abs_b, div_diff;
    logic [2:0]         md_op;
    logic [REG_W-1:0]   md_rd;
    logic               sa, sb, dz, accept, md_accept, a_signed, b_signed, sign_a, sign_b, div_ge;
    logic [WIDTH:0]     mul_sum, div_rs;
    logic [2*WIDTH-1:0] prod;
    assign in_ready_o = state == IDLE && (!out_v_o || out_ready_i);
    assign accept     = in_v_i && in_ready_o && !flush_i;
    assign md_accept  = accept && m_v_i && MULDIV_EN;
    // Execute-stage forwarding wins over memory-stage forwarding because it is younger.
    always_comb begin
        fwd_rs1 = fwd_ex_rs1_i ? out_result_o : fwd_mem_rs1_i ? mem_result_i : rs1_data_i;
        fwd_rs2 = fwd_ex_rs2_i ? out_result_o : fwd_mem_rs2_i ? mem_result_i : rs2_data_i;
        op_a    = rs1_pc_sel_i ? pc_i : fwd_rs1;
        op_b    = imm_v_i ? imm_i : fwd_rs2;
        sra     = $signed(op_a) >>> op_b[SH-1:0];
        case (funct3_i)
            3'b000:  alu_raw = alt_i ? op_a - op_b : op_a + op_b;
            3'b001:  alu_raw = op_a << op_b[SH-1:0];
            3'b010:  alu_raw = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'b011:  alu_raw = {{(WIDTH-1){1'b0}}, op_a < op_b};
            3'b100:  alu_raw = op_a ^ op_b;
            3'b101:  alu_raw = alt_i ? sra : op_a >> op_b[SH-1:0];
            3'b110:  alu_raw = op_a | op_b;
            default: alu_raw = op_a & op_b;
        endcase
        alu_res  = imm_pass_i ? imm_i : alu_raw;
        a_signed = funct3_i != 3'b011 && funct3_i != 3'b101 && funct3_i != 3'b111;
        b_signed = funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b100 || funct3_i == 3'b110;
        sign_a   = a_signed && op_a[WIDTH-1];
        sign_b   = b_signed && op_b[WIDTH-1];
        abs_a    = sign_a ? -op_a : op_a;
        abs_b    = sign_b ? -op_b : op_b;
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        div_rs   = {hi, lo[WIDTH-1]};
        div_ge   = div_rs >= {1'b0, mc};
        div_diff = div_rs[WIDTH-1:0] - mc;
        prod     = (sa ^ sb) ? -{hi, lo} : {hi, lo};
        // A zero divisor leaves an all-ones quotient, which must not be negated.
        quo      = (sa ^ sb) && !dz ? -lo : lo;
        rem      = sa ? -hi : hi;
        md_res   = md_op[2] ? (md_op[1] ? rem : quo) : (md_op == 3'b000 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            busy_o       <= 1'b0;
            out_v_o      <= 1'b0;
            out_rd_o     <= '0;
            out_result_o <= '0;
            out_data_o   <= '0;
            hi           <= '0;
            lo           <= '0;
            mc           <= '0;
            md_op        <= '0;
            md_rd        <= '0;
            md_data      <= '0;
            sa           <= 1'b0;
            sb           <= 1'b0;
            dz           <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            cnt     <= '0;
            busy_o  <= 1'b0;
            out_v_o <= 1'b0;
        end else begin
            if (accept && !md_accept) begin
                out_v_o      <= 1'b1;
                out_rd_o     <= rd_i;
                out_result_o <= alu_res;
                out_data_o   <= fwd_rs2;
            end else if (state == DONE && (!out_v_o || out_ready_i)) begin
                out_v_o      <= 1'b1;
                out_rd_o     <= md_rd;
                out_result_o <= md_res;
                out_data_o   <= md_data;
                state        <= IDLE;
            end else if (out_ready_i) begin
                out_v_o <= 1'b0;
            end
            if (md_accept) begin
                state   <= BUSY;
                busy_o  <= 1'b1;
                cnt     <= '0;
                md_op   <= funct3_i;
                md_rd   <= rd_i;
                md_data <= fwd_rs2;
                sa      <= sign_a;
                sb      <= sign_b;
                dz      <= op_b == '0;
                hi      <= '0;
                lo      <= funct3_i[2] ? abs_a : abs_b;
                mc      <= funct3_i[2] ? abs_b : abs_a;
            end
            // hi:lo is the product for multiply, remainder:quotient for divide.
            if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                if (&cnt) begin
                    state  <= DONE;
                    busy_o <= 1'b0;
                end
                if (md_op[2]) begin
                    hi <= div_ge ? div_diff : div_rs[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], div_ge};
                end else begin
                    {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
                end
            end
        end
    end
endmodule
